uart_word_tx: RTL

- Parametrised successor of the 16-bit two-byte UART word sender.
- Buffers N-byte words in an internal FIFO and serialises each word into bytes for the byte-level UART core, using a valid/ready handshake.
- Counts words per message and can truncate the last word of a message to a programmable number of bytes (generalised odd-length parity).
- Byte order within a word is selectable.

---
 rtl/uart_word_tx_if.sv | 40 ++++
 rtl/uart_word_tx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx_if.sv
// ============================================================================
// Module   : uart_word_tx_if
// Brief    : Word-write, status and byte-stream handshake bundle for uart_word_tx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_word_tx_if #(
    parameter int WORD_BYTES = 2,
    parameter int FIFO_DEPTH = 4
);
    localparam int c_LW = $clog2(FIFO_DEPTH) + 1;

    logic [8*WORD_BYTES-1:0] DATA;
    logic                    ENA;
    logic                    FULL;
    logic [c_LW-1:0]         LEVEL;
    logic                    OVERFLOW;
    logic                    OVF_CLR;
    logic [7:0]              MSG_LEN_IN;
    logic [3:0]              TAIL_BYTES_IN;
    logic [7:0]              TX_DATA;
    logic                    TX_VALID;
    logic                    TX_READY;
    logic                    BUSY;
    logic                    MSG_DONE;
    logic [7:0]              WORD_CNT;

    modport master (
        output DATA, ENA, OVF_CLR, MSG_LEN_IN, TAIL_BYTES_IN, TX_READY,
        input  FULL, LEVEL, OVERFLOW, TX_DATA, TX_VALID, BUSY, MSG_DONE, WORD_CNT
    );

    modport slave (
        input  DATA, ENA, OVF_CLR, MSG_LEN_IN, TAIL_BYTES_IN, TX_READY,
        output FULL, LEVEL, OVERFLOW, TX_DATA, TX_VALID, BUSY, MSG_DONE, WORD_CNT
    );
endinterface

`default_nettype wire

// File: rtl/uart_word_tx.sv
// ============================================================================
// Module   : uart_word_tx
// Brief    : Buffers N-byte words in a FIFO and streams them bytewise to a UART
//            core, with per-message word counting and last-word truncation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_word_tx #(
    parameter int WORD_BYTES = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int LSB_FIRST  = 0
) (
    input  wire           CLK,
    input  wire           RST,
    uart_word_tx_if.slave bus
);

    localparam int               c_W        = 8 * WORD_BYTES;
    localparam int               c_AW       = $clog2(FIFO_DEPTH);
    localparam int               c_LW       = c_AW + 1;
    localparam logic [c_LW-1:0]  c_DEPTH    = c_LW'(FIFO_DEPTH);
    localparam logic [3:0]       c_NB_FULL  = 4'(WORD_BYTES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;

    logic [c_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_LW-1:0] r_level;
    logic            r_ovf;

    logic [1:0]      r_state;
    logic [c_W-1:0]  r_shift;
    logic [3:0]      r_bcnt;
    logic [3:0]      r_nbytes;
    logic            r_last;
    logic            r_valid;
    logic            r_msg_done;
    logic [7:0]      r_word_cnt;

    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_xfer;
    logic [c_W-1:0]  w_head;
    logic [c_W-1:0]  w_shifted;
    logic [7:0]      w_tx_byte;
    logic [7:0]      w_eff_len;
    logic            w_is_last;
    logic            w_tail_ok;
    logic [3:0]      w_nbytes;

    assign w_full = (r_level == c_DEPTH);
    assign w_push = bus.ENA && !w_full;
    assign w_pop  = (r_state == S_IDLE) && (r_level != '0);
    assign w_xfer = r_valid && bus.TX_READY;
    assign w_head = r_mem[r_rd_ptr];

    // A shrinking MSG_LEN_IN can leave WORD_CNT past the end, so ">=" marks last.
    assign w_eff_len = (bus.MSG_LEN_IN == 8'd0) ? 8'd1 : bus.MSG_LEN_IN;
    assign w_is_last = (r_word_cnt >= (w_eff_len - 8'd1));
    assign w_tail_ok = (bus.TAIL_BYTES_IN != 4'd0) && (bus.TAIL_BYTES_IN < c_NB_FULL);
    assign w_nbytes  = (w_is_last && w_tail_ok) ? bus.TAIL_BYTES_IN : c_NB_FULL;

    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_tx_byte = r_shift[7:0];
            assign w_shifted = r_shift >> 8;
        end else begin : g_msb_first
            assign w_tx_byte = r_shift[c_W-1 -: 8];
            assign w_shifted = r_shift << 8;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            // A fresh overflow wins over a simultaneous clear.
            if (bus.ENA && w_full) begin
                r_ovf <= 1'b1;
            end else if (bus.OVF_CLR) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bcnt     <= 4'd0;
            r_nbytes   <= 4'd0;
            r_last     <= 1'b0;
            r_valid    <= 1'b0;
            r_msg_done <= 1'b0;
            r_word_cnt <= 8'd0;
        end else begin
            r_msg_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift  <= w_head;
                        r_nbytes <= w_nbytes;
                        r_last   <= w_is_last;
                        r_bcnt   <= 4'd0;
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_valid <= 1'b1;
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    if (w_xfer) begin
                        if (r_bcnt == (r_nbytes - 4'd1)) begin
                            r_valid <= 1'b0;
                            r_state <= S_IDLE;
                            if (r_last) begin
                                r_word_cnt <= 8'd0;
                                r_msg_done <= 1'b1;
                            end else begin
                                r_word_cnt <= r_word_cnt + 8'd1;
                            end
                        end else begin
                            r_bcnt  <= r_bcnt + 4'd1;
                            r_shift <= w_shifted;
                        end
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.FULL     = w_full;
    assign bus.LEVEL    = r_level;
    assign bus.OVERFLOW = r_ovf;
    assign bus.TX_DATA  = w_tx_byte;
    assign bus.TX_VALID = r_valid;
    assign bus.BUSY     = (r_state != S_IDLE) || (r_level != '0);
    assign bus.MSG_DONE = r_msg_done;
    assign bus.WORD_CNT = r_word_cnt;

endmodule

`default_nettype wire
